sauria_axi4_lite_reg_bridge: RTL

SAURIA_AXI4_LITE_REG_BRIDGE -- requirements
Module: sauria_axi4_lite_reg_bridge

---
 rtl/sauria_axi4_lite_reg_bridge.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sauria_axi4_lite_reg_bridge.sv
// AXI4-Lite slave that turns each write or read into a single request/ack
// transaction on a simple register-file port. Only one access is in flight
// at a time; a fully captured write and a pending read are arbitrated
// round-robin, starting with the write after reset.
module sauria_axi4_lite_reg_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [ADDR_W-1:0]     i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    input  logic [ADDR_W-1:0]     i_araddr,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic                  o_reg_req,
    output logic                  o_reg_we,
    output logic [ADDR_W-1:0]     o_reg_addr,
    output logic [DATA_W-1:0]     o_reg_wdata,
    output logic [DATA_W/8-1:0]   o_reg_wstrb,
    input  logic                  i_reg_ack,
    input  logic [DATA_W-1:0]     i_reg_rdata,
    input  logic                  i_reg_err
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // alive keeps every ready low while reset is asserted and for the first
    // edge after release, without a combinational path from the reset pin.
    logic              alive;
    logic              aw_held;
    logic              w_held;
    logic              rr_read;
    logic [ADDR_W-1:0] aw_addr;
    logic [ADDR_W-1:0] ar_addr;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        b_resp;
    logic [1:0]        r_resp;

    logic aw_fire;
    logic w_fire;
    logic ar_fire;
    logic grant_wr;

    assign aw_fire = o_awready && i_awvalid;
    assign w_fire  = o_wready && i_wvalid;
    assign ar_fire = o_arready && i_arvalid;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, channel readies/valids and register request decode
    always_comb begin
        next_state = state;
        o_awready  = 1'b0;
        o_wready   = 1'b0;
        o_arready  = 1'b0;
        o_bvalid   = 1'b0;
        o_rvalid   = 1'b0;
        o_reg_req  = 1'b0;
        o_reg_we   = 1'b0;
        grant_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (alive) begin
                    o_awready = !aw_held;
                    o_wready  = !w_held;
                    // A read is taken either when no write is starting at all,
                    // or when a complete write is waiting and it is the read's turn.
                    o_arready = (!aw_held && !w_held && !i_awvalid && !i_wvalid) ||
                                (aw_held && w_held && rr_read);
                    if (o_arready && i_arvalid) begin
                        next_state = RD_REQ;
                    end else if (aw_held && w_held) begin
                        next_state = WR_REQ;
                        grant_wr   = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                o_reg_req = 1'b1;
                o_reg_we  = 1'b1;
                if (i_reg_ack) begin
                    next_state = WR_RSP;
                end
            end
            WR_RSP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    next_state = IDLE;
                end
            end
            RD_REQ: begin
                o_reg_req = 1'b1;
                if (i_reg_ack) begin
                    next_state = RD_RSP;
                end
            end
            RD_RSP: begin
                o_rvalid = 1'b1;
                if (i_rready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture address/data halves, arbitration pointer and response payloads
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            alive   <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            rr_read <= 1'b0;
            aw_addr <= '0;
            ar_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            rd_data <= '0;
            b_resp  <= 2'b00;
            r_resp  <= 2'b00;
        end else begin
            alive <= 1'b1;
            if (aw_fire) begin
                aw_addr <= i_awaddr;
                aw_held <= 1'b1;
            end
            if (w_fire) begin
                w_data <= i_wdata;
                w_strb <= i_wstrb;
                w_held <= 1'b1;
            end
            if (grant_wr) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                rr_read <= 1'b1;
            end
            if (ar_fire) begin
                ar_addr <= i_araddr;
                rr_read <= 1'b0;
            end
            if (state == WR_REQ && i_reg_ack) begin
                b_resp <= i_reg_err ? 2'b10 : 2'b00;
            end
            if (state == RD_REQ && i_reg_ack) begin
                r_resp  <= i_reg_err ? 2'b10 : 2'b00;
                rd_data <= i_reg_err ? '0 : i_reg_rdata;
            end
        end
    end

    assign o_reg_addr  = (state == RD_REQ) ? ar_addr : aw_addr;
    assign o_reg_wdata = w_data;
    assign o_reg_wstrb = w_strb;
    assign o_bresp     = b_resp;
    assign o_rresp     = r_resp;
    assign o_rdata     = rd_data;

endmodule
